// File: rtl/boot_progress_monitor_pkg.sv
// boot_mon_pkg: state encodings, page-fault causes and counter helpers for boot_progress_monitor
package boot_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GRACE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] CAUSE_INST_PF  = 32'd12;
    localparam logic [31:0] CAUSE_LOAD_PF  = 32'd13;
    localparam logic [31:0] CAUSE_STORE_PF = 32'd15;

    function automatic logic is_page_fault(input logic [31:0] cause);
        return cause == CAUSE_INST_PF || cause == CAUSE_LOAD_PF || cause == CAUSE_STORE_PF;
    endfunction

    // Counters are carried as 64 bits here and truncated by the caller; max is the all-ones value of the real width.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
        return (v == max) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/boot_progress_monitor_if.sv
// boot_progress_monitor_if: UART TX byte stream and CPU trap bus snooped by the monitor
interface boot_progress_monitor_if;
    logic        uart_valid;
    logic [7:0]  uart_data;
    logic        trap_taken;
    logic [31:0] trap_cause;

    modport master(output uart_valid, uart_data, trap_taken, trap_cause);
    modport slave(input uart_valid, uart_data, trap_taken, trap_cause);
endinterface

// File: rtl/boot_progress_monitor_matcher.sv
// boot_mon_matcher: storage, length register and compare for one programmable byte pattern
module boot_mon_matcher #(
    parameter int PAT_LEN = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic [$clog2(PAT_LEN)-1:0]   pos,
    input  logic [7:0]                   ch,
    input  logic                         len_we,
    input  logic [$clog2(PAT_LEN+1)-1:0] len_in,
    input  logic [PAT_LEN*8-1:0]         win,
    output logic                         hit
);
    localparam int PW = $clog2(PAT_LEN);

    logic [7:0]                   pat [PAT_LEN];
    logic [$clog2(PAT_LEN+1)-1:0] len;

    // Pattern bytes and length are written independently from the config port
    always_ff @(posedge clk) begin
        if (rst) begin
            pat <= '{default: 8'h00};
            len <= '0;
        end else begin
            if (we) pat[pos] <= ch;
            if (len_we) len <= len_in;
        end
    end

    // Last pattern byte aligns with the incoming byte (window byte 0), earlier bytes with older history
    always_comb begin
        hit = len != '0;
        for (int k = 0; k < PAT_LEN; k++)
            if (k < int'(len) && pat[PW'(int'(len) - 1 - k)] != win[8*k +: 8]) hit = 1'b0;
    end
endmodule

// File: rtl/boot_progress_monitor.sv
// boot_progress_monitor: UART pattern / page-fault / cycle watchdog for boot bring-up.
// Defining BOOT_MON_SNAPSHOT_EN adds the periodic snap_pulse output and its divider.
module boot_progress_monitor
    import boot_mon_pkg::*;
#(
    parameter int NUM_PAT      = 4,
    parameter int PAT_LEN      = 8,
    parameter int CNT_W        = 32,
    parameter int MAX_CYCLES   = 300000000,
    parameter int MAX_UART     = 100000,
    parameter int GRACE_CYCLES = 2000000
`ifdef BOOT_MON_SNAPSHOT_EN
    ,
    parameter int SNAP_PERIOD  = 100000,
    parameter int SNAP_LIMIT   = 10000000
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_PAT)-1:0]   cfg_pat,
    input  logic [$clog2(PAT_LEN)-1:0]   cfg_pos,
    input  logic [7:0]                   cfg_char,
    input  logic                         cfg_len_we,
    input  logic [$clog2(PAT_LEN+1)-1:0] cfg_len,
    input  logic [NUM_PAT-1:0]           cfg_stop_mask,
    boot_progress_monitor_if.slave       snoop,
    output logic [1:0]                   state,
    output logic [NUM_PAT-1:0]           match,
    output logic [NUM_PAT-1:0]           match_seen,
    output logic [CNT_W-1:0]             cycle_cnt,
    output logic [CNT_W-1:0]             uart_cnt,
    output logic [CNT_W-1:0]             pgf_cnt,
    output logic                         done,
    output logic                         timeout
`ifdef BOOT_MON_SNAPSHOT_EN
    ,
    output logic                         snap_pulse
`endif
);
    localparam logic [63:0] CNT_MAX    = 64'({CNT_W{1'b1}});
    localparam logic [63:0] CYC_LAST   = 64'(MAX_CYCLES - 1);
    localparam logic [63:0] UART_LAST  = 64'(MAX_UART - 1);
    localparam logic [31:0] GRACE_LAST = 32'(GRACE_CYCLES - 1);

    state_t                     st;
    logic [(PAT_LEN-1)*8-1:0]   hist;
    logic [PAT_LEN*8-1:0]       win;
    logic [NUM_PAT-1:0]         hit;
    logic [31:0]                grace_cnt;
    logic                       active, lim_hit, grace_end, stop_hit;

    assign win       = {hist, snoop.uart_data};
    assign active    = st == ST_RUN || st == ST_GRACE;
    assign lim_hit   = 64'(cycle_cnt) == CYC_LAST || (snoop.uart_valid && 64'(uart_cnt) == UART_LAST);
    assign grace_end = st == ST_GRACE && grace_cnt == GRACE_LAST;
    assign stop_hit  = st == ST_RUN && |(match & cfg_stop_mask);
    assign state     = st;
    assign done      = st == ST_DONE;

    for (genvar p = 0; p < NUM_PAT; p++) begin : g_pat
        boot_mon_matcher #(.PAT_LEN(PAT_LEN)) u_match (
            .clk    (clk),
            .rst    (rst),
            .we     (cfg_we && int'(cfg_pat) == p),
            .pos    (cfg_pos),
            .ch     (cfg_char),
            .len_we (cfg_len_we && int'(cfg_pat) == p),
            .len_in (cfg_len),
            .win    (win),
            .hit    (hit[p])
        );
    end

    // FSM, counters, history and match flags advance together; limit beats grace expiry beats stop match
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= ST_IDLE;
            hist       <= '0;
            match      <= '0;
            match_seen <= '0;
            cycle_cnt  <= '0;
            uart_cnt   <= '0;
            pgf_cnt    <= '0;
            grace_cnt  <= '0;
            timeout    <= 1'b0;
        end else if (!active) begin
            match <= '0;
            if (start) begin
                st         <= ST_RUN;
                hist       <= '0;
                match_seen <= '0;
                cycle_cnt  <= '0;
                uart_cnt   <= '0;
                pgf_cnt    <= '0;
                grace_cnt  <= '0;
                timeout    <= 1'b0;
            end
        end else begin
            match      <= snoop.uart_valid ? hit : '0;
            match_seen <= match_seen | match;
            cycle_cnt  <= CNT_W'(sat_inc(64'(cycle_cnt), CNT_MAX));
            grace_cnt  <= st == ST_GRACE ? grace_cnt + 32'd1 : '0;
            if (snoop.uart_valid) begin
                hist     <= win[(PAT_LEN-1)*8-1:0];
                uart_cnt <= CNT_W'(sat_inc(64'(uart_cnt), CNT_MAX));
            end
            if (snoop.trap_taken && is_page_fault(snoop.trap_cause))
                pgf_cnt <= CNT_W'(sat_inc(64'(pgf_cnt), CNT_MAX));
            if (lim_hit) begin
                st      <= ST_DONE;
                timeout <= 1'b1;
            end else if (grace_end) begin
                st <= ST_DONE;
            end else if (stop_hit) begin
                st <= ST_GRACE;
            end
        end
    end

`ifdef BOOT_MON_SNAPSHOT_EN
    localparam logic [63:0] SNAP_LAST = 64'(SNAP_LIMIT);

    logic [31:0] snap_div;

    // snap_div tracks cycle_cnt modulo SNAP_PERIOD, so no divider is needed on the wide counter
    always_ff @(posedge clk) begin
        if (rst || (!active && start))
            snap_div <= '0;
        else if (active && 64'(cycle_cnt) != CNT_MAX)
            snap_div <= snap_div == 32'(SNAP_PERIOD - 1) ? '0 : snap_div + 32'd1;
    end

    assign snap_pulse = active && snap_div == '0 && cycle_cnt != '0 && 64'(cycle_cnt) <= SNAP_LAST;
`endif
endmodule

// File: tb/tb_boot_progress_monitor.sv
// tb_boot_progress_monitor: table-driven and hand-sequenced checks of boot_progress_monitor
module tb_boot_progress_monitor;
    import boot_mon_pkg::*;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, start_b = 1'b0;
    logic       cfg_we = 1'b0, cfg_len_we = 1'b0;
    logic [1:0] cfg_pat = '0;
    logic [2:0] cfg_pos = '0;
    logic [7:0] cfg_char = '0;
    logic [3:0] cfg_len = '0, cfg_stop_mask = '0;

    always #5 clk = ~clk;

    boot_progress_monitor_if bus();

    logic [1:0]  st_a, st_b, st_c;
    logic [3:0]  mt_a, ms_a, mt_b, ms_b, mt_c, ms_c;
    logic [31:0] cy_a, uc_a, pc_a, cy_b, uc_b, pc_b;
    logic [3:0]  cy_c, uc_c, pc_c;
    logic        dn_a, to_a, dn_b, to_b, dn_c, to_c;
`ifdef BOOT_MON_SNAPSHOT_EN
    logic        sn_a, sn_b, sn_c;
`endif

    boot_progress_monitor #(.MAX_CYCLES(1000), .MAX_UART(5), .GRACE_CYCLES(100)
`ifdef BOOT_MON_SNAPSHOT_EN
        , .SNAP_PERIOD(10), .SNAP_LIMIT(30)
`endif
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_pos(cfg_pos),
        .cfg_char(cfg_char), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_stop_mask(cfg_stop_mask),
        .snoop(bus), .state(st_a), .match(mt_a), .match_seen(ms_a), .cycle_cnt(cy_a), .uart_cnt(uc_a),
        .pgf_cnt(pc_a), .done(dn_a), .timeout(to_a)
`ifdef BOOT_MON_SNAPSHOT_EN
        , .snap_pulse(sn_a)
`endif
    );

    boot_progress_monitor #(.MAX_CYCLES(50)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_pos(cfg_pos),
        .cfg_char(cfg_char), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_stop_mask(cfg_stop_mask),
        .snoop(bus), .state(st_b), .match(mt_b), .match_seen(ms_b), .cycle_cnt(cy_b), .uart_cnt(uc_b),
        .pgf_cnt(pc_b), .done(dn_b), .timeout(to_b)
`ifdef BOOT_MON_SNAPSHOT_EN
        , .snap_pulse(sn_b)
`endif
    );

    boot_progress_monitor #(.CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .start(start_b), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_pos(cfg_pos),
        .cfg_char(cfg_char), .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_stop_mask(cfg_stop_mask),
        .snoop(bus), .state(st_c), .match(mt_c), .match_seen(ms_c), .cycle_cnt(cy_c), .uart_cnt(uc_c),
        .pgf_cnt(pc_c), .done(dn_c), .timeout(to_c)
`ifdef BOOT_MON_SNAPSHOT_EN
        , .snap_pulse(sn_c)
`endif
    );

    typedef struct {
        logic        st;
        logic        uv;
        logic [7:0]  ud;
        logic        tt;
        logic [31:0] tc;
        logic [1:0]  e_state;
        logic [3:0]  e_match;
        logic [31:0] e_uc;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0, n_pass = 0;

    function automatic vec_t mk(input logic s, input logic uv, input logic [7:0] ud, input logic tt,
                                input logic [31:0] tc, input logic [1:0] es, input logic [3:0] em,
                                input logic [31:0] eu, input logic [31:0] ep);
        mk = '{s, uv, ud, tt, tc, es, em, eu, ep};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input int p, input int pos, input logic [7:0] c);
        cfg_we   = 1'b1;
        cfg_pat  = 2'(p);
        cfg_pos  = 3'(pos);
        cfg_char = c;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wr_len(input int p, input int l);
        cfg_len_we = 1'b1;
        cfg_pat    = 2'(p);
        cfg_len    = 4'(l);
        tick();
        cfg_len_we = 1'b0;
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            start          = vecs[i].st;
            bus.uart_valid = vecs[i].uv;
            bus.uart_data  = vecs[i].ud;
            bus.trap_taken = vecs[i].tt;
            bus.trap_cause = vecs[i].tc;
            tick();
            start          = 1'b0;
            bus.uart_valid = 1'b0;
            bus.trap_taken = 1'b0;
            chk($sformatf("v%0d state", i), 64'(st_a), 64'(vecs[i].e_state));
            chk($sformatf("v%0d match", i), 64'(mt_a), 64'(vecs[i].e_match));
            chk($sformatf("v%0d uart_cnt", i), 64'(uc_a), 64'(vecs[i].e_uc));
            chk($sformatf("v%0d pgf_cnt", i), 64'(pc_a), 64'(vecs[i].e_pc));
        end
    endtask

    initial begin
        int bad;
        bus.uart_valid = 1'b0;
        bus.uart_data  = 8'h00;
        bus.trap_taken = 1'b0;
        bus.trap_cause = 32'd0;

        // segment 1: "ab# " with traps, stop pattern enters GRACE
        vecs.push_back(mk(1, 0, 0,   0, 0,  ST_RUN,   4'b0000, 0, 0));
        vecs.push_back(mk(0, 0, 0,   1, 12, ST_RUN,   4'b0000, 0, 1));
        vecs.push_back(mk(0, 0, 0,   1, 13, ST_RUN,   4'b0000, 0, 2));
        vecs.push_back(mk(0, 0, 0,   1, 8,  ST_RUN,   4'b0000, 0, 2));
        vecs.push_back(mk(0, 0, 0,   1, 15, ST_RUN,   4'b0000, 0, 3));
        vecs.push_back(mk(0, 0, 0,   1, 2,  ST_RUN,   4'b0000, 0, 3));
        vecs.push_back(mk(0, 1, "a", 0, 0,  ST_RUN,   4'b0000, 1, 3));
        vecs.push_back(mk(0, 1, "b", 0, 0,  ST_RUN,   4'b0000, 2, 3));
        vecs.push_back(mk(0, 1, "#", 0, 0,  ST_RUN,   4'b0000, 3, 3));
        vecs.push_back(mk(0, 1, " ", 0, 0,  ST_RUN,   4'b0001, 4, 3));
        vecs.push_back(mk(0, 0, 0,   0, 0,  ST_GRACE, 4'b0000, 4, 3));
        // segment 2: UART limit on the same byte that completes the stop pattern
        vecs.push_back(mk(1, 0, 0,   0, 0,  ST_RUN,   4'b0000, 0, 0));
        vecs.push_back(mk(0, 1, "x", 0, 0,  ST_RUN,   4'b0000, 1, 0));
        vecs.push_back(mk(0, 1, "y", 0, 0,  ST_RUN,   4'b0000, 2, 0));
        vecs.push_back(mk(0, 1, "z", 0, 0,  ST_RUN,   4'b0000, 3, 0));
        vecs.push_back(mk(0, 1, "#", 0, 0,  ST_RUN,   4'b0000, 4, 0));
        vecs.push_back(mk(0, 1, " ", 0, 0,  ST_DONE,  4'b0001, 5, 0));
        vecs.push_back(mk(0, 0, 0,   0, 0,  ST_DONE,  4'b0000, 5, 0));
        // segment 3: overlapping "aa" (p0) and "a" (p1)
        vecs.push_back(mk(1, 0, 0,   0, 0,  ST_RUN,   4'b0000, 0, 0));
        vecs.push_back(mk(0, 1, "a", 0, 0,  ST_RUN,   4'b0010, 1, 0));
        vecs.push_back(mk(0, 1, "a", 0, 0,  ST_RUN,   4'b0011, 2, 0));
        vecs.push_back(mk(0, 1, "a", 0, 0,  ST_RUN,   4'b0011, 3, 0));
        vecs.push_back(mk(0, 0, 0,   0, 0,  ST_RUN,   4'b0000, 3, 0));

        repeat (2) tick();
        chk("rst state", 64'(st_a), 64'(ST_IDLE));
        chk("rst match", 64'(mt_a), 64'(0));
        chk("rst match_seen", 64'(ms_a), 64'(0));
        chk("rst cycle_cnt", 64'(cy_a), 64'(0));
        chk("rst uart_cnt", 64'(uc_a), 64'(0));
        chk("rst pgf_cnt", 64'(pc_a), 64'(0));
        chk("rst done", 64'(dn_a), 64'(0));
        chk("rst timeout", 64'(to_a), 64'(0));
        rst = 1'b0;

        bus.trap_taken = 1'b1;
        bus.trap_cause = 32'd12;
        repeat (3) tick();
        bus.trap_taken = 1'b0;
        tick();
        chk("idle trap pgf_cnt", 64'(pc_a), 64'(0));
        chk("idle cycle_cnt hold", 64'(cy_a), 64'(0));

        wr_byte(0, 0, "#");
        wr_byte(0, 1, " ");
        wr_len(0, 2);
        cfg_stop_mask = 4'b0001;
        run(0, 10);
        bad = 0;
        repeat (99) begin
            tick();
            if (st_a !== 2'(ST_GRACE)) bad++;
        end
        chk("grace hold cycles", 64'(bad), 64'(0));
        tick();
        chk("grace end state", 64'(st_a), 64'(ST_DONE));
        chk("grace end done", 64'(dn_a), 64'(1));
        chk("grace end timeout", 64'(to_a), 64'(0));
        chk("grace end cycle_cnt", 64'(cy_a), 64'(110));
        chk("grace end match_seen", 64'(ms_a), 64'(1));
        repeat (3) tick();
        chk("done cycle_cnt frozen", 64'(cy_a), 64'(110));
        chk("done uart_cnt frozen", 64'(uc_a), 64'(4));

        run(11, 17);
        chk("uart limit timeout", 64'(to_a), 64'(1));

        wr_byte(0, 0, "a");
        wr_byte(0, 1, "a");
        wr_byte(1, 0, "a");
        wr_len(1, 1);
        cfg_stop_mask = 4'b0000;
        run(18, 22);
        chk("overlap match_seen", 64'(ms_a), 64'(4'b0011));

        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("cyc start state", 64'(st_b), 64'(ST_RUN));
        repeat (49) tick();
        chk("cyc last run state", 64'(st_b), 64'(ST_RUN));
        chk("cyc last run cycle_cnt", 64'(cy_b), 64'(49));
        tick();
        chk("cyc limit state", 64'(st_b), 64'(ST_DONE));
        chk("cyc limit timeout", 64'(to_b), 64'(1));
        chk("cyc limit done", 64'(dn_b), 64'(1));
        chk("cyc limit match_seen", 64'(ms_b), 64'(0));
        chk("cyc limit cycle_cnt", 64'(cy_b), 64'(50));

        bus.trap_taken = 1'b1;
        bus.trap_cause = 32'd13;
        repeat (14) tick();
        chk("sat pgf 14", 64'(pc_c), 64'(14));
        tick();
        chk("sat pgf 15", 64'(pc_c), 64'(15));
        repeat (5) tick();
        bus.trap_taken = 1'b0;
        chk("sat pgf held", 64'(pc_c), 64'(15));
        chk("sat cycle_cnt", 64'(cy_c), 64'(15));
        chk("sat no timeout", 64'(st_c), 64'(ST_RUN));

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst state", 64'(st_a), 64'(ST_IDLE));
        chk("midrst match_seen", 64'(ms_a), 64'(0));
        chk("midrst cycle_cnt", 64'(cy_a), 64'(0));
        chk("midrst uart_cnt", 64'(uc_a), 64'(0));
        chk("midrst pgf_cnt", 64'(pc_a), 64'(0));
        chk("midrst c state", 64'(st_c), 64'(ST_IDLE));
        chk("midrst c pgf_cnt", 64'(pc_c), 64'(0));
        chk("midrst b timeout", 64'(to_b), 64'(0));

        start = 1'b1;
        tick();
        start = 1'b0;
        bus.uart_valid = 1'b1;
        bus.uart_data  = "a";
        tick();
        chk("cfg cleared match 1", 64'(mt_a), 64'(0));
        tick();
        bus.uart_valid = 1'b0;
        chk("cfg cleared match 2", 64'(mt_a), 64'(0));

`ifdef BOOT_MON_SNAPSHOT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk($sformatf("snap k=%0d", k), 64'(sn_a), 64'(k == 10 || k == 20 || k == 30));
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
